// File: rtl/cpu_param.sv
// cpu_param: 3-cycle accumulator-free register CPU driving a synchronous RAM.
// Define CPU_SHIFT_EN to add SHL (op D) and SHR (op E); otherwise those opcodes are illegal.
module cpu_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  output logic [7:0]        status
);
  localparam int LW = $clog2(NREG);
  typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, EXECUTE = 2'd2, HALT = 2'd3} state_t;
  state_t state, state_nx;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] r [NREG];
  logic              z, c, ill;
  logic [7:0]        op;
  logic [15:0]       imm;
  logic [LW-1:0]     ra, rb, rc;
  logic [DATA_W-1:0] a, b, res;
  logic [DATA_W:0]   wide;
  logic              alu, cout, legal;
  logic              unused_fields;
  assign op  = instr[31:24];
  assign imm = instr[15:0];
  assign ra  = instr[16 +: LW];
  assign rb  = instr[8 +: LW];
  assign rc  = instr[0 +: LW];
  assign a   = r[ra];
  assign b   = r[rb];
  assign unused_fields = ^instr[23:0];
  assign status = {3'b000, ill, c, z, state};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = DECODE;
      DECODE:  state_nx = (op == 8'hFF) ? HALT : EXECUTE;
      EXECUTE: state_nx = FETCH;
      default: state_nx = HALT;
    endcase
  end
  // ALU result, carry/borrow and opcode legality for the instruction in DECODE
  always_comb begin
    res   = '0;
    wide  = '0;
    cout  = 1'b0;
    alu   = 1'b1;
    legal = 1'b1;
    case (op)
      8'h07: res = a & b;
      8'h08: res = a | b;
      8'h09: res = a ^ b;
      8'h0A: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[DATA_W-1:0];
        cout = wide[DATA_W];
      end
      8'h0B: begin
        wide = {1'b0, a} - {1'b0, b};
        res  = wide[DATA_W-1:0];
        cout = wide[DATA_W];
      end
`ifdef CPU_SHIFT_EN
      8'h0D: res = a << b[4:0];
      8'h0E: res = a >> b[4:0];
`endif
      8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0C, 8'hFF: alu = 1'b0;
      default: begin
        alu   = 1'b0;
        legal = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc      <= '0;
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      instr   <= '0;
      z       <= 1'b0;
      c       <= 1'b0;
      ill     <= 1'b0;
      for (int i = 0; i < NREG; i++) r[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          instr <= q[31:0];
          pc    <= pc + ADDR_W'(1);
        end
        DECODE: begin
          if (!legal) ill <= 1'b1;
          case (op)
            8'h01: begin
              address <= imm[ADDR_W-1:0];
              wren    <= 1'b0;
            end
            8'h02: begin
              address <= imm[ADDR_W-1:0];
              data    <= a;
              wren    <= 1'b1;
            end
            8'h03: r[ra][15:0] <= imm;
            8'h04: r[ra][31:16] <= imm;
            8'h05: if (a == '0) pc <= pc + imm[ADDR_W-1:0];
            8'h06: r[rb] <= a;
            8'h0C: pc <= pc + imm[ADDR_W-1:0];
            default: wren <= 1'b0;
          endcase
          if (alu) begin
            r[rc] <= res;
            z     <= (res == '0);
            c     <= cout;
          end
        end
        EXECUTE: begin
          if (op == 8'h01) r[ra] <= q;
          address <= pc;
          wren    <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: directed checks of cpu_param against a behavioural RAM.
module tb_cpu_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] q, data;
  logic [15:0] address;
  logic        wren;
  logic [7:0]  status;
  logic [31:0] mem [65536];
  int          checks = 0;
  int          failures = 0;
  int          wren_cnt = 0;

  cpu_param dut (.clk(clk), .rst_n(rst_n), .q(q), .data(data), .address(address),
                 .wren(wren), .status(status));

  always #5 clk = ~clk;
  assign q = mem[address];
  always @(posedge clk) if (wren) mem[address] <= data;
  always @(posedge clk) if (wren) wren_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'hFF000000;
    wren_cnt = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset values
    hold_reset();
    #12;
    chk("rst_status", {24'h0, status}, 32'h0);
    chk("rst_address", {16'h0, address}, 32'h0);
    chk("rst_wren", {31'h0, wren}, 32'h0);
    chk("rst_data", data, 32'h0);

    // LOADLI, LOADHI, HALT
    mem[0] = 32'h03010005; mem[1] = 32'h04010001; mem[2] = 32'hFF000000;
    release_reset();
    step(9);
    chk("halt_r1", dut.r[1], 32'h00010005);
    chk("halt_state", {30'h0, status[1:0]}, 32'h3);
    step(6);
    chk("halt_r1_hold", dut.r[1], 32'h00010005);
    chk("halt_addr_hold", {16'h0, address}, 32'h2);
    chk("halt_pc_hold", {16'h0, dut.pc}, 32'h3);

    // ADD then SUB with borrow
    hold_reset();
    mem[0] = 32'h03010007; mem[1] = 32'h03020005; mem[2] = 32'h0A010203; mem[3] = 32'h0B020104;
    release_reset();
    step(16);
    chk("add_r3", dut.r[3], 32'd12);
    chk("sub_r4", dut.r[4], 32'hFFFFFFFE);
    chk("sub_flags", {24'h0, status}, 32'h0B);

    // XOR to zero sets Z, clears C
    hold_reset();
    mem[0] = 32'h03010007; mem[1] = 32'h03020005; mem[2] = 32'h0B020104; mem[3] = 32'h09010105;
    release_reset();
    step(16);
    chk("xor_r5", dut.r[5], 32'h0);
    chk("xor_flags", {24'h0, status}, 32'h07);

    // ADD carry-out with zero result
    hold_reset();
    mem[0] = 32'h0301FFFF; mem[1] = 32'h0401FFFF; mem[2] = 32'h03020001; mem[3] = 32'h0A010203;
    release_reset();
    step(16);
    chk("addc_r3", dut.r[3], 32'h0);
    chk("addc_flags", {24'h0, status}, 32'h0F);

    // AND, OR, MOV, in-place ADD
    hold_reset();
    mem[0] = 32'h030100F0; mem[1] = 32'h03020FF0; mem[2] = 32'h07010203; mem[3] = 32'h08010204;
    mem[4] = 32'h06010500; mem[5] = 32'h0A010101;
    release_reset();
    step(22);
    chk("and_r3", dut.r[3], 32'h000000F0);
    chk("or_r4", dut.r[4], 32'h00000FF0);
    chk("mov_r5", dut.r[5], 32'h000000F0);
    chk("self_add_r1", dut.r[1], 32'h000001E0);

    // STORE then LOAD
    hold_reset();
    mem[0] = 32'h0301BEEF; mem[1] = 32'h0401DEAD; mem[2] = 32'h02010040; mem[3] = 32'h01020040;
    release_reset();
    step(8);
    chk("st_wren", {31'h0, wren}, 32'h1);
    chk("st_addr", {16'h0, address}, 32'h40);
    chk("st_data", data, 32'hDEADBEEF);
    step(1);
    chk("st_wren_drop", {31'h0, wren}, 32'h0);
    chk("st_mem", mem[16'h40], 32'hDEADBEEF);
    step(3);
    chk("ld_r2", dut.r[2], 32'hDEADBEEF);
    chk("ld_next_addr", {16'h0, address}, 32'h4);
    step(4);
    chk("st_wren_count", wren_cnt, 32'd1);

    // JUMPZ taken
    hold_reset();
    for (int i = 0; i < 5; i++) mem[i] = 32'h0;
    mem[5] = 32'h0501FFFE;
    release_reset();
    step(18);
    chk("jz_taken", {16'h0, address}, 32'h4);

    // JUMPZ not taken
    hold_reset();
    mem[0] = 32'h03010001;
    for (int i = 1; i < 5; i++) mem[i] = 32'h0;
    mem[5] = 32'h0501FFFE;
    release_reset();
    step(18);
    chk("jz_not_taken", {16'h0, address}, 32'h6);

    // JUMP wraps through 0xFFFF
    hold_reset();
    mem[0] = 32'h0C00FFFE; mem[16'hFFFF] = 32'h0C000001;
    release_reset();
    step(3);
    chk("jmp_to_ffff", {16'h0, address}, 32'hFFFF);
    step(3);
    chk("jmp_wrap", {16'h0, address}, 32'h1);

    // reset asserted during STORE EXECUTE
    hold_reset();
    mem[0] = 32'h0301BEEF; mem[1] = 32'h0401DEAD; mem[2] = 32'h02010040;
    release_reset();
    step(8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wren", {31'h0, wren}, 32'h0);
    chk("arst_addr", {16'h0, address}, 32'h0);
    chk("arst_data", data, 32'h0);
    chk("arst_status", {24'h0, status}, 32'h0);
    chk("arst_r1", dut.r[1], 32'h0);
    step(2);
    chk("arst_no_write", mem[16'h40], 32'hFF000000);
    release_reset();
    step(1);
    chk("arst_refetch", dut.instr, 32'h0301BEEF);
    step(2);
    chk("arst_pc_addr", {16'h0, address}, 32'h1);

    // op D: SHL or illegal
    hold_reset();
    mem[0] = 32'h03010001; mem[1] = 32'h03020004; mem[2] = 32'h0D010203;
    release_reset();
    step(12);
`ifdef CPU_SHIFT_EN
    chk("shl_r3", dut.r[3], 32'h10);
    chk("shl_status", {24'h0, status}, 32'h03);
`else
    chk("opd_r3", dut.r[3], 32'h0);
    chk("opd_status", {24'h0, status}, 32'h13);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
